// File: rtl/start_seq_pkg.sv
// start_seq_pkg: shared state encoding, register addresses and CTRL bit positions.
package start_seq_pkg;
  typedef enum logic [1:0] {IDLE, START, RUN} state_e;
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd1;
  localparam logic [1:0] ADDR_CYCLES = 2'd2;
  localparam logic [1:0] ADDR_IRQEN = 2'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 4;
endpackage

// File: rtl/mysystem_start_sequencer.sv
// mysystem_start_sequencer: Avalon-MM start/done sequencer with timeout, abort, overrun and irq.
module mysystem_start_sequencer
  import start_seq_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_RESET = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        acc_start,
  output logic        acc_abort,
  input  logic        acc_done,
  output logic        irq
);
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d, tmo_q, tmo_d;
  logic done_q, done_d, to_q, to_d, ovr_q, ovr_d, irqen_q, irqen_d;
  logic start_q, abort_q, irq_q;
  logic wr, ctrl_wr, start_cmd, abort_cmd, clear_cmd, busy, running;
  logic done_hit, to_hit, abort_hit, go;
  always_comb begin
    wr = chipselect & ~write_n;
    ctrl_wr = wr & (address == ADDR_CTRL);
    start_cmd = ctrl_wr & writedata[CTRL_START] & ~writedata[CTRL_ABORT];
    abort_cmd = ctrl_wr & writedata[CTRL_ABORT];
    clear_cmd = ctrl_wr & writedata[CTRL_CLEAR];
    busy = state_q != IDLE;
    running = state_q == RUN;
    // Priority: done beats timeout, both beat a software abort.
    done_hit = running & acc_done;
    to_hit = running & ~acc_done & (tmo_q != '0) & (cnt_q == tmo_q);
    abort_hit = busy & abort_cmd & ~done_hit & ~to_hit;
    go = ~busy & start_cmd;
    state_d = go ? START
            : (done_hit | to_hit | abort_hit) ? IDLE
            : (state_q == START) ? RUN : state_q;
    cnt_d = go ? '0
          : (running & ~acc_done & ~to_hit & ~&cnt_q) ? cnt_q + 32'd1 : cnt_q;
    done_d = done_hit | (done_q & ~clear_cmd & ~go);
    to_d = to_hit | (to_q & ~clear_cmd & ~go);
    ovr_d = (busy & start_cmd) | (ovr_q & ~clear_cmd);
    tmo_d = (wr & (address == ADDR_TIMEOUT)) ? writedata : tmo_q;
    irqen_d = (wr & (address == ADDR_IRQEN)) ? writedata[0] : irqen_q;
    readdata = (address == ADDR_CTRL) ? {28'b0, ovr_q, to_q, done_q, busy}
             : (address == ADDR_TIMEOUT) ? tmo_q
             : (address == ADDR_CYCLES) ? cnt_q : {31'b0, irqen_q};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tmo_q <= TIMEOUT_RESET;
      done_q <= 1'b0;
      to_q <= 1'b0;
      ovr_q <= 1'b0;
      irqen_q <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      done_q <= done_d;
      to_q <= to_d;
      ovr_q <= ovr_d;
      irqen_q <= irqen_d;
      start_q <= state_d == START;
      abort_q <= to_hit | abort_hit;
      irq_q <= irqen_d & (done_d | to_d);
    end
  end
  assign acc_start = start_q;
  assign acc_abort = abort_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_mysystem_start_sequencer.sv
// tb_mysystem_start_sequencer: directed scenario tests for the start/done sequencer.
module tb_mysystem_start_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] address = 2'd0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic acc_start, acc_abort, acc_done, irq;
  int errors = 0;
  int checks = 0;
  int abort_cnt = 0;
  int start_cnt = 0;

  mysystem_start_sequencer #(.TIMEOUT_RESET(32'd7)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .acc_start(acc_start), .acc_abort(acc_abort), .acc_done(acc_done), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    abort_cnt <= abort_cnt + int'(acc_abort);
    start_cnt <= start_cnt + int'(acc_start);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    step();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rd(2'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected %h", v, 32'h0); end
    rd(2'd1, v);
    checks++; if (v !== 32'd7) begin errors++; $display("FAIL reset_timeout: got %h expected %h", v, 32'd7); end
    rd(2'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cycles: got %h expected %h", v, 32'h0); end
    rd(2'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_irqen: got %h expected %h", v, 32'h0); end
    checks++; if ({acc_start, acc_abort, irq} !== 3'b000) begin errors++; $display("FAIL reset_outputs: got %b expected 000", {acc_start, acc_abort, irq}); end
  endtask

  task automatic test_regs();
    logic [31:0] v;
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL irqen_rw: got %h expected %h", v, 32'h1); end
    wr(2'd3, 32'h0);
    wr(2'd1, 32'h1234_5678);
    rd(2'd1, v);
    checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL timeout_rw: got %h expected %h", v, 32'h1234_5678); end
    wr(2'd0, 32'h3);
    checks++; if (acc_start !== 1'b0 || acc_abort !== 1'b0) begin errors++; $display("FAIL start_abort_idle: got %b%b expected 00", acc_start, acc_abort); end
    rd(2'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL start_abort_idle_status: got %h expected %h", v, 32'h0); end
    wr(2'd1, 32'h0);
  endtask

  task automatic test_basic_run();
    logic [31:0] v;
    int s0;
    s0 = start_cnt;
    wr(2'd0, 32'h1);
    checks++; if (acc_start !== 1'b1) begin errors++; $display("FAIL basic_start_hi: got %b expected 1", acc_start); end
    step();
    checks++; if (acc_start !== 1'b0) begin errors++; $display("FAIL basic_start_lo: got %b expected 0", acc_start); end
    repeat (5) step();
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
    rd(2'd0, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL basic_status: got %h expected %h", v, 32'h2); end
    rd(2'd2, v);
    checks++; if (v !== 32'd5) begin errors++; $display("FAIL basic_cycles: got %0d expected 5", v); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL basic_start_pulses: got %0d expected 1", start_cnt - s0); end
  endtask

  task automatic test_timeout();
    logic [31:0] v;
    int a0;
    wr(2'd1, 32'd10);
    wr(2'd3, 32'h1);
    a0 = abort_cnt;
    wr(2'd0, 32'h1);
    repeat (11) step();
    rd(2'd2, v);
    checks++; if (v !== 32'd10) begin errors++; $display("FAIL timeout_live_cycles: got %0d expected 10", v); end
    rd(2'd0, v);
    checks++; if (v !== 32'h1 || acc_abort !== 1'b0) begin errors++; $display("FAIL timeout_pre: got status %h abort %b expected 1/0", v, acc_abort); end
    step();
    checks++; if (acc_abort !== 1'b1) begin errors++; $display("FAIL timeout_abort_hi: got %b expected 1", acc_abort); end
    step();
    checks++; if (acc_abort !== 1'b0) begin errors++; $display("FAIL timeout_abort_lo: got %b expected 0", acc_abort); end
    rd(2'd0, v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL timeout_status: got %h expected %h", v, 32'h4); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL timeout_irq: got %b expected 1", irq); end
    rd(2'd2, v);
    checks++; if (v !== 32'd10) begin errors++; $display("FAIL timeout_cycles: got %0d expected 10", v); end
    checks++; if (abort_cnt - a0 !== 1) begin errors++; $display("FAIL timeout_abort_count: got %0d expected 1", abort_cnt - a0); end
  endtask

  task automatic test_abort();
    logic [31:0] v;
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    step();
    repeat (2) step();
    wr(2'd0, 32'h2);
    checks++; if (acc_abort !== 1'b1) begin errors++; $display("FAIL abort_hi: got %b expected 1", acc_abort); end
    rd(2'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL abort_status: got %h expected %h", v, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL abort_irq: got %b expected 0", irq); end
    step();
    checks++; if (acc_abort !== 1'b0) begin errors++; $display("FAIL abort_lo: got %b expected 0", acc_abort); end
  endtask

  task automatic test_overrun_clear();
    logic [31:0] v;
    wr(2'd0, 32'h1);
    step();
    wr(2'd0, 32'h1);
    rd(2'd0, v);
    checks++; if (v !== 32'h9) begin errors++; $display("FAIL overrun_status: got %h expected %h", v, 32'h9); end
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
    rd(2'd0, v);
    checks++; if (v !== 32'hA) begin errors++; $display("FAIL overrun_done_status: got %h expected %h", v, 32'hA); end
    rd(2'd2, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL overrun_cycles: got %0d expected 1", v); end
    wr(2'd0, 32'h10);
    rd(2'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL clear_status: got %h expected %h", v, 32'h0); end
  endtask

  task automatic test_race();
    logic [31:0] v;
    int a0;
    wr(2'd1, 32'd4);
    a0 = abort_cnt;
    wr(2'd0, 32'h1);
    step();
    repeat (4) step();
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
    checks++; if (acc_abort !== 1'b0) begin errors++; $display("FAIL race_abort: got %b expected 0", acc_abort); end
    rd(2'd0, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL race_status: got %h expected %h", v, 32'h2); end
    rd(2'd2, v);
    checks++; if (v !== 32'd4) begin errors++; $display("FAIL race_cycles: got %0d expected 4", v); end
    step();
    checks++; if (abort_cnt !== a0) begin errors++; $display("FAIL race_abort_count: got %0d expected %0d", abort_cnt, a0); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] v;
    int a0;
    wr(2'd1, 32'd0);
    wr(2'd3, 32'h1);
    wr(2'd0, 32'h1);
    repeat (3) step();
    a0 = abort_cnt;
    #2 reset = 1'b1;
    #1;
    checks++; if ({acc_start, acc_abort, irq} !== 3'b000) begin errors++; $display("FAIL midrst_outputs: got %b expected 000", {acc_start, acc_abort, irq}); end
    rd(2'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL midrst_status: got %h expected %h", v, 32'h0); end
    rd(2'd1, v);
    checks++; if (v !== 32'd7) begin errors++; $display("FAIL midrst_timeout: got %h expected %h", v, 32'd7); end
    step();
    #2 reset = 1'b0;
    repeat (3) step();
    checks++; if (abort_cnt !== a0) begin errors++; $display("FAIL midrst_no_abort: got %0d expected %0d", abort_cnt, a0); end
  endtask

  initial begin
    acc_done = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    step();
    test_reset();
    test_regs();
    test_basic_run();
    test_timeout();
    test_abort();
    test_overrun_clear();
    test_race();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
